// File: rtl/m92_obj_list.sv
// m92_obj_list: CPU-triggered sprite RAM DMA into a double-buffered 64-bit object list.
// Define M92_OBJ_LIST_REVERSE_EN to replay each line from the last entry down to 0.
module m92_obj_list #(
    parameter int          MAX_OBJS   = 256,
    parameter int          RAM_AW     = 10,
    parameter logic [63:0] NULL_ENTRY = 64'h0000_0000_0000_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              dma_start,
    input  logic [8:0]        dma_count,
    output logic              dma_busy,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic [15:0]       ram_data,
    input  logic              hpulse,
    input  logic              vpulse,
    input  logic              obj_next,
    output logic [63:0]       obj_out,
    output logic              obj_valid
);

    localparam int         IW    = $clog2(MAX_OBJS);
    localparam logic [8:0] MAX_N = 9'(MAX_OBJS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COPY,
        S_DONE
    } dma_state_t;

    dma_state_t state;
    dma_state_t state_nx;

    logic [8:0]        count;
    logic [8:0]        entry;
    logic [8:0]        entry_inc;
    logic [8:0]        cnt_clamp;
    logic [8:0]        back_count;
    logic [8:0]        front_count;
    logic [8:0]        rd_idx;
    logic [1:0]        word;
    logic [47:0]       asm_r;
    logic              dma_bank;
    logic              front_bank;
    logic              swap_pending;
    logic              swap_now;
    logic              last_word;
    logic              busy_r;
    logic              rd_live;
    logic              valid_r;
    logic [RAM_AW-1:0] addr_r;
    logic [RAM_AW-1:0] addr_nx;
    logic [63:0]       rd_q;
    logic [63:0]       mem [2*MAX_OBJS];

    always_comb begin
        cnt_clamp = (dma_count > MAX_N) ? MAX_N : dma_count;
        entry_inc = entry + 9'd1;
        last_word = (word == 2'd3) && (entry_inc == count);
        addr_nx   = RAM_AW'({entry, word}) + RAM_AW'(1);
        // A running DMA still owns the back bank, so the swap waits for IDLE.
        swap_now  = ce && vpulse && swap_pending && (state == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (ce) begin
            unique case (state)
                S_IDLE: begin
                    if (dma_start) begin
                        state_nx = (cnt_clamp == 9'd0) ? S_DONE : S_COPY;
                    end
                end
                S_COPY: begin
                    if (last_word) begin
                        state_nx = S_DONE;
                    end
                end
                S_DONE:  state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_r       <= 1'b0;
            addr_r       <= '0;
            count        <= '0;
            entry        <= '0;
            word         <= '0;
            asm_r        <= '0;
            dma_bank     <= 1'b1;
            back_count   <= '0;
            swap_pending <= 1'b0;
        end else if (ce) begin
            unique case (state)
                S_IDLE: begin
                    if (dma_start) begin
                        busy_r   <= 1'b1;
                        count    <= cnt_clamp;
                        entry    <= '0;
                        word     <= '0;
                        addr_r   <= '0;
                        dma_bank <= swap_now ? front_bank : ~front_bank;
                    end
                end
                S_COPY: begin
                    unique case (word)
                        2'd0:    asm_r[15:0]  <= ram_data;
                        2'd1:    asm_r[31:16] <= ram_data;
                        2'd2:    asm_r[47:32] <= ram_data;
                        default: ;
                    endcase
                    word <= word + 2'd1;
                    if (word == 2'd3) begin
                        entry <= entry_inc;
                    end
                    // No address past the final word, so the bus never wraps.
                    if (!last_word) begin
                        addr_r <= addr_nx;
                    end
                end
                S_DONE: begin
                    busy_r       <= 1'b0;
                    back_count   <= count;
                    swap_pending <= 1'b1;
                end
                default: ;
            endcase
            if (swap_now) begin
                swap_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && ce && (state == S_COPY) && (word == 2'd3)) begin
            mem[{dma_bank, entry[IW-1:0]}] <= {ram_data, asm_r};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            front_bank  <= 1'b0;
            front_count <= '0;
        end else if (swap_now) begin
            front_bank  <= ~front_bank;
            front_count <= back_count;
        end
    end

`ifdef M92_OBJ_LIST_REVERSE_EN
    logic       rd_exh;
    logic [8:0] fc_eff;

    assign fc_eff = swap_now ? back_count : front_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_idx <= '0;
            rd_exh <= 1'b1;
        end else if (ce) begin
            if (hpulse) begin
                rd_exh <= (fc_eff == 9'd0);
                rd_idx <= (fc_eff == 9'd0) ? 9'd0 : fc_eff - 9'd1;
            end else if (obj_next && !rd_exh) begin
                if (rd_idx == 9'd0) begin
                    rd_exh <= 1'b1;
                end else begin
                    rd_idx <= rd_idx - 9'd1;
                end
            end
        end
    end

    assign rd_live = !rd_exh && (rd_idx < front_count);
`else
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_idx <= '0;
        end else if (ce) begin
            if (hpulse) begin
                rd_idx <= '0;
            end else if (obj_next && (rd_idx != MAX_N)) begin
                rd_idx <= rd_idx + 9'd1;
            end
        end
    end

    assign rd_live = rd_idx < front_count;
`endif

    always_ff @(posedge clk) begin
        rd_q <= mem[{front_bank, rd_idx[IW-1:0]}];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= rd_live;
        end
    end

    assign dma_busy  = busy_r;
    assign ram_addr  = addr_r;
    assign obj_valid = valid_r;
    assign obj_out   = valid_r ? rd_q : NULL_ENTRY;

endmodule

// File: tb/tb_m92_obj_list.sv
// tb_m92_obj_list: directed stimulus with a scoreboard queue drained by a monitor.
// RAM model returns 16'h1000 + word address one clk after the address.
module tb_m92_obj_list;

    localparam int K_VALID = 0;
    localparam int K_OUT   = 1;
    localparam int K_BUSY  = 2;
    localparam int K_ADDR  = 3;
    localparam int K_BCE   = 4;
    localparam int K_MAXA  = 5;

    typedef struct {
        string       name;
        int          kind;
        logic [63:0] exp;
    } exp_t;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        ce        = 1'b0;
    logic        dma_start = 1'b0;
    logic [8:0]  dma_count = '0;
    logic        hpulse    = 1'b0;
    logic        vpulse    = 1'b0;
    logic        obj_next  = 1'b0;
    logic [15:0] ram_data  = '0;
    logic        dma_busy;
    logic [9:0]  ram_addr;
    logic [63:0] obj_out;
    logic        obj_valid;

    int         errors   = 0;
    int         checks   = 0;
    int         busy_ce  = 0;
    int         busy_run = 0;
    logic [9:0] max_addr = '0;
    exp_t       sb[$];

    always #5 clk = ~clk;

    m92_obj_list dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .dma_start (dma_start),
        .dma_count (dma_count),
        .dma_busy  (dma_busy),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .hpulse    (hpulse),
        .vpulse    (vpulse),
        .obj_next  (obj_next),
        .obj_out   (obj_out),
        .obj_valid (obj_valid)
    );

    always @(posedge clk) begin
        ram_data <= 16'h1000 + 16'(ram_addr);
        if (ce && dma_busy) busy_ce <= busy_ce + 1;
        if (ram_addr > max_addr) max_addr <= ram_addr;
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            while (sb.size() > 0) begin
                exp_t        e;
                logic [63:0] act;
                e = sb.pop_front();
                case (e.kind)
                    K_VALID: act = 64'(obj_valid);
                    K_OUT:   act = obj_out;
                    K_BUSY:  act = 64'(dma_busy);
                    K_ADDR:  act = 64'(ram_addr);
                    K_BCE:   act = 64'(busy_run);
                    default: act = 64'(max_addr);
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h, want %h", e.name, act, e.exp);
                end
            end
        end
    end

    function automatic logic [63:0] ent(input int e);
        logic [15:0] b;
        b = 16'h1000 + 16'(4 * e);
        return {b + 16'd3, b + 16'd2, b + 16'd1, b};
    endfunction

    task automatic expect_v(input string n, input int k, input logic [63:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic chk_ent(input string n, input logic [63:0] v);
        expect_v({n, ".valid"}, K_VALID, 64'd1);
        expect_v({n, ".out"}, K_OUT, v);
    endtask

    task automatic chk_null(input string n);
        expect_v({n, ".valid"}, K_VALID, 64'd0);
        expect_v({n, ".out"}, K_OUT, 64'h0);
    endtask

    task automatic tick(input logic h, input logic v, input logic n, input logic s);
        @(negedge clk);
        ce = 1'b1; hpulse = h; vpulse = v; obj_next = n; dma_start = s;
        @(negedge clk);
        ce = 1'b0; hpulse = 1'b0; vpulse = 1'b0; obj_next = 1'b0; dma_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(); tick(0, 0, 0, 0); endtask
    task automatic hp();   tick(1, 0, 0, 0); endtask
    task automatic vh();   tick(1, 1, 0, 0); endtask
    task automatic nx();   tick(0, 0, 1, 0); endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && dma_busy; i++) idle();
    endtask

    task automatic run_dma(input int n, input int budget);
        int base;
        dma_count = 9'(n);
        base = busy_ce;
        tick(0, 0, 0, 1);
        wait_idle(budget);
        busy_run = busy_ce - base;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int base;

        // reset and idle
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        hp();
        chk_null("reset");
        expect_v("reset.busy", K_BUSY, 64'd0);
        expect_v("reset.addr", K_ADDR, 64'd0);

        // basic DMA of 3 entries, no swap before vpulse
        run_dma(3, 40);
        expect_v("basic.busy_ce", K_BCE, 64'd13);
        expect_v("basic.busy", K_BUSY, 64'd0);
        expect_v("basic.last_addr", K_ADDR, 64'd11);
        hp();
        chk_null("noswap.h1");
        hp();
        chk_null("noswap.h2");
        vh();
        chk_ent("basic.e0", 64'h1003_1002_1001_1000);
        nx();
        chk_ent("basic.e1", 64'h1007_1006_1005_1004);
        nx();
        chk_ent("basic.e2", 64'h100B_100A_1009_1008);
        nx();
        chk_null("basic.end");
        nx();
        chk_null("basic.sat");
        hp();
        chk_ent("basic.rewind", 64'h1003_1002_1001_1000);

        // (a) dma_start while busy is ignored
        dma_count = 9'd4;
        base = busy_ce;
        tick(0, 0, 0, 1);
        repeat (5) idle();
        dma_count = 9'd1;
        tick(0, 0, 0, 1);
        wait_idle(40);
        busy_run = busy_ce - base;
        expect_v("busystart.busy_ce", K_BCE, 64'd17);
        expect_v("busystart.last_addr", K_ADDR, 64'd15);
        vh();
        chk_ent("busystart.e0", ent(0));
        repeat (3) nx();
        chk_ent("busystart.e3", ent(3));
        nx();
        chk_null("busystart.end");

        // (b) hpulse wins over obj_next
        hp();
        nx();
        nx();
        chk_ent("hpnext.pre", ent(2));
        tick(1, 0, 1, 0);
        chk_ent("hpnext", ent(0));

        // (c) vpulse during COPY with a swap already pending
        run_dma(2, 20);
        dma_count = 9'd5;
        tick(0, 0, 0, 1);
        repeat (6) idle();
        vh();
        expect_v("vcopy.busy", K_BUSY, 64'd1);
        chk_ent("vcopy.e0", ent(0));
        repeat (3) nx();
        chk_ent("vcopy.e3_old", ent(3));
        nx();
        chk_null("vcopy.old_end");
        wait_idle(40);
        hp();
        repeat (4) nx();
        chk_null("vcopy.nov_end");
        vh();
        repeat (4) nx();
        chk_ent("vcopy.e4_new", ent(4));
        nx();
        chk_null("vcopy.new_end");

        // count 0
        run_dma(0, 10);
        expect_v("zero.busy_ce", K_BCE, 64'd1);
        hp();
        chk_ent("zero.before_v", ent(0));
        vh();
        chk_null("zero.after_v");

        // count 300 clamps to 256
        run_dma(300, 1100);
        expect_v("clamp.busy_ce", K_BCE, 64'd1025);
        expect_v("clamp.max_addr", K_MAXA, 64'd1023);
        expect_v("clamp.last_addr", K_ADDR, 64'd1023);
        vh();
        chk_ent("clamp.e0", ent(0));
        repeat (128) nx();
        chk_ent("clamp.e128", ent(128));
        repeat (127) nx();
        chk_ent("clamp.e255", 64'h13FF_13FE_13FD_13FC);
        nx();
        chk_null("clamp.end");
        nx();
        chk_null("clamp.sat");

        // reset after 5 entries of a 10-entry DMA
        dma_count = 9'd10;
        tick(0, 0, 0, 1);
        repeat (20) idle();
        expect_v("midrst.busy_before", K_BUSY, 64'd1);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        expect_v("midrst.busy", K_BUSY, 64'd0);
        expect_v("midrst.addr", K_ADDR, 64'd0);
        chk_null("midrst.out");
        hp();
        chk_null("midrst.h");
        vh();
        chk_null("midrst.v");
        repeat (12) idle();
        vh();
        chk_null("midrst.v2");

        repeat (3) @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d undrained, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/m92_obj_list.md
Name: m92_obj_list

Overview:
- Upstream feeder for the GA22 sprite renderer.
- A CPU-triggered DMA copies sprite attribute RAM (16-bit words, 4 per object) into a double-buffered 64-bit shadow list.
- The shadow list is swapped in at vertical sync.
- Each scanline it replays the active list in order, one entry per `obj_next` request, on the 64-bit `obj_out` bus that GA22 consumes as `obj_in`.

Parameters:
- MAX_OBJS, 256: shadow list depth per bank, in entries.
- RAM_AW, 10: sprite RAM word-address width; must satisfy 4*MAX_OBJS <= 2**RAM_AW.
- NULL_ENTRY, 64'h0000_0000_0000_0000: value driven on `obj_out` when no valid entry remains.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- ce  in  1  13.33 MHz enable; never high on two consecutive clk cycles
- dma_start  in  1  one-ce pulse; CPU requests a list copy
- dma_count  in  9  number of entries to copy, 0..256
- dma_busy  out  1  high while the copy engine is active
- ram_addr  out  RAM_AW  sprite RAM word address
- ram_data  in  16  sprite RAM read data; valid on the clk after `ram_addr` changes
- hpulse  in  1  line start, qualified with ce
- vpulse  in  1  frame start, qualified with ce
- obj_next  in  1  consumer has taken the current entry, qualified with ce
- obj_out  out  64  current entry: word k of the object occupies bits [16k+15:16k]
- obj_valid  out  1  `obj_out` holds a real entry

Behaviour:
- Reset values, all registers, applied at any clk with reset_n=0 regardless of ce:
  - dma_busy=0, ram_addr=0, obj_out=NULL_ENTRY, obj_valid=0.
  - front bank=0, front_count=0, rd_idx=0, swap_pending=0, DMA state IDLE.
- Reset mid-DMA aborts the copy. The back bank's contents are then don't-care.
- DMA FSM, all transitions on ce:
  - IDLE
    - On dma_start: latch count = min(dma_count, MAX_OBJS); set entry=0, word=0; go to COPY. dma_busy=1 from the next clk.
    - If the latched count is 0: skip COPY, go straight to DONE.
  - COPY
    - Each ce: ram_addr <= 4*entry + word.
    - On the following ce, capture ram_data into the assembly register at slot `word`.
    - This is pipelined: address for word n+1 is issued on the same ce that word n is captured.
    - After capturing word 3, write the assembled entry into back bank[entry] and increment entry.
    - When entry reaches count, go to DONE.
    - Throughput: one entry per 4 ce; total 4*count+1 ce.
  - DONE
    - Set back_count=count and swap_pending=1; go to IDLE with dma_busy=0.
  - dma_start while dma_busy=1 is ignored.
  - A second completed DMA before the swap overwrites back_count; swap_pending stays 1.
- Swap: on ce with vpulse=1 and swap_pending=1:
  - Toggle the front bank, set front_count=back_count, clear swap_pending.
  - A DMA in progress at that moment keeps writing into the bank that was back when it started. Track this as a per-DMA bank latch; the swap is then deferred until that DMA's DONE.
- Readout:
  - On ce with hpulse: rd_idx <= 0.
  - Otherwise, on ce with obj_next: rd_idx <= rd_idx+1, saturating at MAX_OBJS.
  - hpulse wins over a simultaneous obj_next.
  - When vpulse and hpulse coincide, the swap takes effect first; index 0 is then read from the new front bank.
- Output registers:
  - obj_out is front_bank[rd_idx] through a synchronous RAM, registered one clk after rd_idx updates. It is therefore stable before the next ce.
  - obj_valid = (rd_idx < front_count), registered on the same clk.
  - When obj_valid=0, obj_out=NULL_ENTRY.
- Arithmetic:
  - rd_idx and entry are 9-bit.
  - ram_addr is truncated to RAM_AW bits, with no wrap inside a DMA.

Optional Feature:
- Macro: M92_OBJ_LIST_REVERSE_EN.
- With the macro defined:
  - Readout runs from index front_count-1 down to 0.
  - hpulse loads rd_idx = front_count-1.
  - obj_next decrements rd_idx. obj_valid drops after index 0 is consumed; rd_idx then holds at an "exhausted" state.
  - front_count=0 gives obj_valid=0 immediately.
- Without the macro: ascending order as above. No extra logic is present.

Test Plan:
- Reset and idle:
  - Stimulus: hold reset_n=0 for 3 clk, release, pulse hpulse.
  - Required: obj_valid=0, obj_out=NULL_ENTRY, dma_busy=0, ram_addr=0.
- Basic DMA and swap:
  - Stimulus: RAM word i = 16'h1000+i; dma_count=3; dma_start; then vpulse+hpulse.
  - Required: dma_busy high for exactly 13 ce. Entry 0 = 64'h1003_1002_1001_1000, entry 2 = 64'h100B_100A_1009_1008.
  - Required: three obj_next pulses step through the entries, then obj_valid=0.
- No swap before vpulse:
  - Stimulus: complete a DMA, issue several hpulses without vpulse.
  - Required: the old list (initially empty) is still presented; the new list appears only after vpulse.
- Boundary counts:
  - Stimulus: dma_count=0, then dma_count=300.
  - Required: count 0 gives obj_valid=0 after the swap. Count 300 is clamped, copies 256 entries (ram_addr max 1023), and front_count=256.
- Collisions:
  - Stimulus: (a) dma_start while busy; (b) hpulse and obj_next on the same ce; (c) vpulse during COPY.
  - Required: (a) ignored, no restart; (b) rd_idx=0; (c) no swap until DONE, then swap at the next vpulse with the full list.
- Reset mid-DMA:
  - Stimulus: drop reset_n after 5 entries of a 10-entry DMA.
  - Required: dma_busy=0, front_count=0, no swap at the next vpulse.
